// File: rtl/hazard_fwd_ctrl.sv
// hazard_fwd_ctrl
//   Hazard detection and forwarding control for the 5-stage WISC core.
//   Tracks destination-register info for the instructions in EX, MEM and WB,
//   stalls decode on a load-use dependency and produces registered XX/XM
//   forwarding selects that execute consumes while the instruction sits in EX.
//   Optional build macro: HAZ_PERF_EN adds saturating stall/flush counters.
module hazard_fwd_ctrl #(
   parameter int REG_ADDR_W = 3,
   parameter int PERF_W     = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  id_valid,
   input  logic [REG_ADDR_W-1:0] id_rs,
   input  logic                  id_rs_used,
   input  logic [REG_ADDR_W-1:0] id_rt,
   input  logic                  id_rt_used,
   input  logic                  id_wr_en,
   input  logic [REG_ADDR_W-1:0] id_wr_reg,
   input  logic [1:0]            id_res_src,
   input  logic                  flush,
   input  logic                  mem_stall,
   output logic                  stall_id,
   output logic                  forward_XX_A,
   output logic                  forward_XX_B,
   output logic                  forward_XM_A,
   output logic                  forward_XM_B,
   output logic [1:0]            forward_XX_sel,
   output logic [1:0]            forward_XM_sel
`ifdef HAZ_PERF_EN
   ,
   output logic [PERF_W-1:0]     perf_stall_cnt,
   output logic [PERF_W-1:0]     perf_flush_cnt
`endif
);

   localparam logic [1:0] SRC_LOAD = 2'b10;

   // shadow entries: {valid, wr_en, wr_reg, res_src} per stage
   logic                  r_ex_valid;
   logic                  r_ex_wr_en;
   logic [REG_ADDR_W-1:0] r_ex_wr_reg;
   logic [1:0]            r_ex_res_src;
   logic                  r_mem_valid;
   logic                  r_mem_wr_en;
   logic [REG_ADDR_W-1:0] r_mem_wr_reg;
   logic [1:0]            r_mem_res_src;
   logic                  r_wb_valid;
   logic                  r_wb_wr_en;
   logic [REG_ADDR_W-1:0] r_wb_wr_reg;
   logic [1:0]            r_wb_res_src;

   // registered forwarding outputs
   logic                  r_fwd_xx_a;
   logic                  r_fwd_xx_b;
   logic                  r_fwd_xm_a;
   logic                  r_fwd_xm_b;
   logic [1:0]            r_fwd_xx_sel;
   logic [1:0]            r_fwd_xm_sel;

   logic                  w_ex_hit_rs;
   logic                  w_ex_hit_rt;
   logic                  w_mem_hit_rs;
   logic                  w_mem_hit_rt;
   logic                  w_load_use;
   logic                  w_stall;
   logic                  w_ex_bubble;

   // producer/consumer matching, load-use detection and stall priority
   always_comb begin
      w_ex_hit_rs  = 1'b0;
      w_ex_hit_rt  = 1'b0;
      w_mem_hit_rs = 1'b0;
      w_mem_hit_rt = 1'b0;
      w_load_use   = 1'b0;
      w_stall      = 1'b0;
      w_ex_hit_rs  = r_ex_valid  & r_ex_wr_en  & id_rs_used & (r_ex_wr_reg  == id_rs);
      w_ex_hit_rt  = r_ex_valid  & r_ex_wr_en  & id_rt_used & (r_ex_wr_reg  == id_rt);
      w_mem_hit_rs = r_mem_valid & r_mem_wr_en & id_rs_used & (r_mem_wr_reg == id_rs);
      w_mem_hit_rt = r_mem_valid & r_mem_wr_en & id_rt_used & (r_mem_wr_reg == id_rt);
      w_load_use   = id_valid & (w_ex_hit_rs | w_ex_hit_rt) & (r_ex_res_src == SRC_LOAD);
      // reset wins, then a frozen pipeline, then a redirect cancels the load-use stall
      if (rst) begin
         w_stall = 1'b0;
      end else if (mem_stall) begin
         w_stall = 1'b1;
      end else if (flush) begin
         w_stall = 1'b0;
      end else begin
         w_stall = w_load_use;
      end
   end

   // EX receives a bubble on a redirect or on a load-use stall
   assign w_ex_bubble = flush | w_load_use;
   assign stall_id    = w_stall;

   // shadow pipeline: clear, hold under mem_stall, else advance
   always_ff @(posedge clk) begin
      if (rst) begin
         r_ex_valid    <= 1'b0;
         r_ex_wr_en    <= 1'b0;
         r_ex_wr_reg   <= {REG_ADDR_W{1'b0}};
         r_ex_res_src  <= 2'b00;
         r_mem_valid   <= 1'b0;
         r_mem_wr_en   <= 1'b0;
         r_mem_wr_reg  <= {REG_ADDR_W{1'b0}};
         r_mem_res_src <= 2'b00;
         r_wb_valid    <= 1'b0;
         r_wb_wr_en    <= 1'b0;
         r_wb_wr_reg   <= {REG_ADDR_W{1'b0}};
         r_wb_res_src  <= 2'b00;
      end else if (mem_stall) begin
         r_ex_valid    <= r_ex_valid;
         r_mem_valid   <= r_mem_valid;
         r_wb_valid    <= r_wb_valid;
      end else begin
         r_wb_valid    <= r_mem_valid;
         r_wb_wr_en    <= r_mem_wr_en;
         r_wb_wr_reg   <= r_mem_wr_reg;
         r_wb_res_src  <= r_mem_res_src;
         r_mem_valid   <= r_ex_valid;
         r_mem_wr_en   <= r_ex_wr_en;
         r_mem_wr_reg  <= r_ex_wr_reg;
         r_mem_res_src <= r_ex_res_src;
         if (w_ex_bubble) begin
            r_ex_valid   <= 1'b0;
            r_ex_wr_en   <= 1'b0;
            r_ex_wr_reg  <= {REG_ADDR_W{1'b0}};
            r_ex_res_src <= 2'b00;
         end else begin
            r_ex_valid   <= id_valid;
            r_ex_wr_en   <= id_wr_en;
            r_ex_wr_reg  <= id_wr_reg;
            r_ex_res_src <= id_res_src;
         end
      end
   end

   // forwarding selects registered as ID advances into EX
   always_ff @(posedge clk) begin
      if (rst) begin
         r_fwd_xx_a   <= 1'b0;
         r_fwd_xx_b   <= 1'b0;
         r_fwd_xm_a   <= 1'b0;
         r_fwd_xm_b   <= 1'b0;
         r_fwd_xx_sel <= 2'b00;
         r_fwd_xm_sel <= 2'b00;
      end else if (mem_stall) begin
         r_fwd_xx_a   <= r_fwd_xx_a;
         r_fwd_xx_b   <= r_fwd_xx_b;
         r_fwd_xm_a   <= r_fwd_xm_a;
         r_fwd_xm_b   <= r_fwd_xm_b;
         r_fwd_xx_sel <= r_fwd_xx_sel;
         r_fwd_xm_sel <= r_fwd_xm_sel;
      end else if (w_ex_bubble) begin
         r_fwd_xx_a   <= 1'b0;
         r_fwd_xx_b   <= 1'b0;
         r_fwd_xm_a   <= 1'b0;
         r_fwd_xm_b   <= 1'b0;
         r_fwd_xx_sel <= 2'b00;
         r_fwd_xm_sel <= 2'b00;
      end else begin
         r_fwd_xx_a   <= id_valid & w_ex_hit_rs;
         r_fwd_xx_b   <= id_valid & w_ex_hit_rt;
         r_fwd_xm_a   <= id_valid & w_mem_hit_rs;
         r_fwd_xm_b   <= id_valid & w_mem_hit_rt;
         // one producer per stage, so a single select per stage suffices
         r_fwd_xx_sel <= (id_valid & (w_ex_hit_rs | w_ex_hit_rt))   ? r_ex_res_src  : 2'b00;
         r_fwd_xm_sel <= (id_valid & (w_mem_hit_rs | w_mem_hit_rt)) ? r_mem_res_src : 2'b00;
      end
   end

   assign forward_XX_A   = r_fwd_xx_a;
   assign forward_XX_B   = r_fwd_xx_b;
   assign forward_XM_A   = r_fwd_xm_a;
   assign forward_XM_B   = r_fwd_xm_b;
   assign forward_XX_sel = r_fwd_xx_sel;
   assign forward_XM_sel = r_fwd_xm_sel;

`ifdef HAZ_PERF_EN
   localparam logic [PERF_W-1:0] PERF_MAX = {PERF_W{1'b1}};
   localparam logic [PERF_W-1:0] PERF_ONE = {{(PERF_W-1){1'b0}}, 1'b1};

   logic [PERF_W-1:0] r_perf_stall_cnt;
   logic [PERF_W-1:0] r_perf_flush_cnt;

   // saturating counts of load-use bubbles and accepted redirects
   always_ff @(posedge clk) begin
      if (rst) begin
         r_perf_stall_cnt <= {PERF_W{1'b0}};
         r_perf_flush_cnt <= {PERF_W{1'b0}};
      end else begin
         if (!mem_stall && !flush && w_load_use && (r_perf_stall_cnt != PERF_MAX)) begin
            r_perf_stall_cnt <= r_perf_stall_cnt + PERF_ONE;
         end else begin
            r_perf_stall_cnt <= r_perf_stall_cnt;
         end
         if (!mem_stall && flush && (r_perf_flush_cnt != PERF_MAX)) begin
            r_perf_flush_cnt <= r_perf_flush_cnt + PERF_ONE;
         end else begin
            r_perf_flush_cnt <= r_perf_flush_cnt;
         end
      end
   end

   assign perf_stall_cnt = r_perf_stall_cnt;
   assign perf_flush_cnt = r_perf_flush_cnt;
`endif

endmodule

// File: tb/tb_hazard_fwd_ctrl.sv
// Scoreboard bench for hazard_fwd_ctrl: each driven cycle checks the
// combinational stall and queues the forwarding outputs expected after the edge.
module tb_hazard_fwd_ctrl;

   localparam logic [1:0] SP  = 2'b00;
   localparam logic [1:0] PC  = 2'b01;
   localparam logic [1:0] LD  = 2'b10;
   localparam logic [1:0] ALU = 2'b11;
   localparam logic [7:0] F0  = 8'h00;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       id_valid = 1'b0;
   logic [2:0] id_rs = 3'd0;
   logic       id_rs_used = 1'b0;
   logic [2:0] id_rt = 3'd0;
   logic       id_rt_used = 1'b0;
   logic       id_wr_en = 1'b0;
   logic [2:0] id_wr_reg = 3'd0;
   logic [1:0] id_res_src = 2'b00;
   logic       flush = 1'b0;
   logic       mem_stall = 1'b0;
   logic       stall_id;
   logic       forward_XX_A, forward_XX_B, forward_XM_A, forward_XM_B;
   logic [1:0] forward_XX_sel, forward_XM_sel;
`ifdef HAZ_PERF_EN
   logic [15:0] perf_stall_cnt, perf_flush_cnt;
`endif

   hazard_fwd_ctrl #(.REG_ADDR_W(3), .PERF_W(16)) dut (
      .clk(clk), .rst(rst), .id_valid(id_valid),
      .id_rs(id_rs), .id_rs_used(id_rs_used),
      .id_rt(id_rt), .id_rt_used(id_rt_used),
      .id_wr_en(id_wr_en), .id_wr_reg(id_wr_reg), .id_res_src(id_res_src),
      .flush(flush), .mem_stall(mem_stall), .stall_id(stall_id),
      .forward_XX_A(forward_XX_A), .forward_XX_B(forward_XX_B),
      .forward_XM_A(forward_XM_A), .forward_XM_B(forward_XM_B),
      .forward_XX_sel(forward_XX_sel), .forward_XM_sel(forward_XM_sel)
`ifdef HAZ_PERF_EN
      , .perf_stall_cnt(perf_stall_cnt), .perf_flush_cnt(perf_flush_cnt)
`endif
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;
   logic [7:0] exp_q[$];
   int         tag_q[$];

   // count one comparison and report it when it disagrees
   task automatic check_val(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [7:0] fv(input bit xxa, input bit xxb, input bit xma, input bit xmb,
                                     input logic [1:0] xs, input logic [1:0] ms);
      return {xxa, xxb, xma, xmb, xs, ms};
   endfunction

   // one cycle of decode stimulus; stall is checked before the edge, forwards after
   task automatic drv(input int step, input bit r, input bit v,
                      input logic [2:0] rs, input bit rsu, input logic [2:0] rt, input bit rtu,
                      input bit we, input logic [2:0] wr, input logic [1:0] src,
                      input bit fl, input bit ms, input bit exp_stall, input logic [7:0] exp_fwd);
      @(negedge clk);
      rst = r; id_valid = v; id_rs = rs; id_rs_used = rsu; id_rt = rt; id_rt_used = rtu;
      id_wr_en = we; id_wr_reg = wr; id_res_src = src; flush = fl; mem_stall = ms;
      #1;
      check_val($sformatf("stall@%0d", step), {15'd0, stall_id}, {15'd0, exp_stall});
      exp_q.push_back(exp_fwd);
      tag_q.push_back(step);
   endtask

   // pop the expected forwarding pattern just after each active edge
   always @(posedge clk) begin
      #1;
      if (exp_q.size() != 0) begin
         check_val($sformatf("fwd@%0d", tag_q.pop_front()),
                   {8'd0, forward_XX_A, forward_XX_B, forward_XM_A, forward_XM_B,
                    forward_XX_sel, forward_XM_sel},
                   {8'd0, exp_q.pop_front()});
      end
   end

   initial begin
      drv(0,  1, 0, 3'd0, 0, 3'd0, 0, 0, 3'd0, SP,  0, 0, 0, F0);
      drv(1,  1, 0, 3'd0, 0, 3'd0, 0, 0, 3'd0, SP,  0, 1, 0, F0);
      // ADD r1 ; ADD r2,r1,r3 -> XX forward from ALU
      drv(2,  0, 1, 3'd2, 1, 3'd3, 1, 1, 3'd1, ALU, 0, 0, 0, F0);
      drv(3,  0, 1, 3'd1, 1, 3'd3, 1, 1, 3'd2, ALU, 0, 0, 0, fv(1, 0, 0, 0, ALU, SP));
      // LD r4 ; ADD r5,r4,r4 -> one stall then XM forward of load data
      drv(4,  0, 1, 3'd6, 1, 3'd0, 0, 1, 3'd4, LD,  0, 0, 0, F0);
      drv(5,  0, 1, 3'd4, 1, 3'd4, 1, 1, 3'd5, ALU, 0, 0, 1, F0);
      drv(6,  0, 1, 3'd4, 1, 3'd4, 1, 1, 3'd5, ALU, 0, 0, 0, fv(0, 0, 1, 1, SP, LD));
      // JAL r7 ; NOP ; ADD using r7 -> XM forward of pc_inc
      drv(7,  0, 1, 3'd0, 0, 3'd0, 0, 1, 3'd7, PC,  0, 0, 0, F0);
      drv(8,  0, 0, 3'd0, 0, 3'd0, 0, 0, 3'd0, SP,  0, 0, 0, F0);
      drv(9,  0, 1, 3'd7, 1, 3'd2, 1, 1, 3'd3, ALU, 0, 0, 0, fv(0, 0, 1, 0, SP, PC));
      // load-use coincident with flush: no stall, EX bubble, load moves on to MEM
      drv(10, 0, 1, 3'd1, 1, 3'd0, 0, 1, 3'd6, LD,  0, 0, 0, F0);
      drv(11, 0, 1, 3'd6, 1, 3'd0, 0, 1, 3'd1, ALU, 1, 0, 0, F0);
      drv(12, 0, 1, 3'd6, 1, 3'd3, 1, 1, 3'd2, ALU, 0, 0, 0, fv(0, 0, 1, 0, SP, LD));
      // mem_stall for 3 cycles while XX_A is up (flush ignored mid-stall), then resume
      drv(13, 0, 1, 3'd2, 1, 3'd0, 0, 1, 3'd4, ALU, 0, 0, 0, fv(1, 0, 0, 0, ALU, SP));
      for (int s = 14; s <= 16; s++)
         drv(s, 0, 1, 3'd4, 1, 3'd2, 1, 1, 3'd5, ALU, (s == 15), 1, 1, fv(1, 0, 0, 0, ALU, SP));
      drv(17, 0, 1, 3'd4, 1, 3'd2, 1, 1, 3'd5, ALU, 0, 0, 0, fv(1, 0, 0, 1, ALU, ALU));
      // reset while a load-use stall is pending: everything clears
      drv(18, 0, 1, 3'd0, 1, 3'd0, 0, 1, 3'd6, LD,  0, 0, 0, F0);
      drv(19, 1, 1, 3'd6, 1, 3'd0, 0, 1, 3'd7, ALU, 0, 0, 0, F0);
`ifdef HAZ_PERF_EN
      @(posedge clk); #2;
      check_val("perf_stall_rst", perf_stall_cnt, 16'd0);
      check_val("perf_flush_rst", perf_flush_cnt, 16'd0);
`endif
      drv(20, 0, 1, 3'd6, 1, 3'd0, 0, 1, 3'd7, ALU, 0, 0, 0, F0);
      // two more load-use events (rs side, then rt side)
      drv(21, 0, 1, 3'd0, 1, 3'd0, 0, 1, 3'd1, LD,  0, 0, 0, F0);
      drv(22, 0, 1, 3'd1, 1, 3'd0, 0, 1, 3'd2, ALU, 0, 0, 1, F0);
      drv(23, 0, 1, 3'd1, 1, 3'd0, 0, 1, 3'd2, ALU, 0, 0, 0, fv(0, 0, 1, 0, SP, LD));
      drv(24, 0, 1, 3'd5, 1, 3'd0, 0, 1, 3'd3, LD,  0, 0, 0, F0);
      drv(25, 0, 1, 3'd2, 1, 3'd3, 1, 1, 3'd4, ALU, 0, 0, 1, F0);
      drv(26, 0, 1, 3'd2, 1, 3'd3, 1, 1, 3'd4, ALU, 0, 0, 0, fv(0, 0, 0, 1, SP, LD));
      drv(27, 0, 0, 3'd0, 0, 3'd0, 0, 0, 3'd0, SP,  0, 0, 0, F0);
      repeat (3) @(posedge clk);
      #2;
      if (exp_q.size() != 0)
         check_val("drain", exp_q.size(), 16'd0);
`ifdef HAZ_PERF_EN
      check_val("perf_stall_end", perf_stall_cnt, 16'd2);
      check_val("perf_flush_end", perf_flush_cnt, 16'd0);
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/hazard_fwd_ctrl.md
Name: hazard_fwd_ctrl

Overview:
- Pipeline hazard and forwarding controller for the 5-stage WISC core.
- Keeps a shadow copy of destination-register info for the EX, MEM and WB stages.
- Detects load-use hazards and stalls decode.
- Produces registered XX/XM forwarding selects that the execute stage consumes in the same cycle the instruction occupies EX.
- Sits beside the ID/EX pipeline register, driven by decode, `flush` from execute, and memory stall.

Parameters:
- REG_ADDR_W, 3, register specifier width (8 GPRs).
- PERF_W, 16, width of performance counters (optional feature only).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- id_valid  in  1  decode holds a real instruction
- id_rs  in  REG_ADDR_W  source A specifier
- id_rs_used  in  1  instruction reads rs
- id_rt  in  REG_ADDR_W  source B / store-data specifier
- id_rt_used  in  1  instruction reads rt
- id_wr_en  in  1  instruction writes the register file
- id_wr_reg  in  REG_ADDR_W  destination specifier
- id_res_src  in  2  result source: 00 specOps, 01 pc_inc, 10 readMemData (load), 11 aluOut
- flush  in  1  execute-stage branch/jump redirect
- mem_stall  in  1  instruction/data memory not done; freeze pipeline
- stall_id  out  1  hold PC and IF/ID, inject bubble into EX
- forward_XX_A, forward_XX_B  out  1  EX operand from XM latch
- forward_XM_A, forward_XM_B  out  1  EX operand from MW latch
- forward_XX_sel  out  2  XM-latch source, result-source encoding
- forward_XM_sel  out  2  MW-latch source, result-source encoding

Behaviour:
- Shadow entries EX, MEM, WB; each holds {valid, wr_en, wr_reg, res_src}.
- A producer matches when valid & wr_en & wr_reg == the consumer specifier & the consumer's *_used bit is set.
- Reset: all entries invalid. All outputs 0 the cycle after rst is sampled high, and held 0 while rst is high.
- Load-use:
  - Condition: id_valid, EX entry matches rs or rt, and EX.res_src==10.
  - stall_id is asserted combinationally in that cycle.
  - Next edge: EX entry becomes a bubble (valid=0); ID is held.
  - Exactly one stall cycle per load-use; a back-to-back dependent pair gives 1 stall, then XM forwarding with sel=10.
- Forward computation:
  - Computed from ID versus the current EX/MEM entries; registered at the edge ID advances into EX.
  - forward_XX_* is set if the EX entry matches (res_src != 10 guaranteed by the stall rule); forward_XX_sel = EX.res_src.
  - forward_XM_* is set if the MEM entry matches; forward_XM_sel = MEM.res_src.
  - When both XX and XM match, both are asserted; execute gives XX priority. The selects are emitted unmodified.
  - XX and XM share one sel each across A/B. If A and B match different producers in the same stage (impossible: one dest per stage), the sel is unique by construction.
  - WB-to-ID hazards need no forwarding; the register file bypasses write-to-read.
- Advance (no stall, no mem_stall): WB<=MEM, MEM<=EX, EX<=ID (valid=id_valid).
- flush:
  - EX<=bubble and forward outputs are cleared at the edge.
  - stall_id is forced 0 (flush wins over load-use in the same cycle).
  - MEM<=EX and WB<=MEM still advance.
- mem_stall:
  - Highest priority: all entries and forward outputs hold.
  - stall_id is forced 1.
  - flush is ignored while mem_stall=1; execute re-presents it.
- Bubble entries never match; invalid ID never triggers a stall.
- rst mid-stall: everything clears next edge; no residual stall.

Optional Feature:
- HAZ_PERF_EN defined adds outputs perf_stall_cnt[PERF_W-1:0] and perf_flush_cnt[PERF_W-1:0]:
  - perf_stall_cnt increments on each load-use bubble.
  - perf_flush_cnt increments on each accepted flush (not under mem_stall).
  - Both saturate at all-ones and clear on rst.
- Undefined: ports and counters absent; core behaviour identical.

Test Plan:
- ADD r1 (res_src 11) then ADD r2,r1,r3 -> second in EX: forward_XX_A=1, forward_XX_sel=11, no stall.
- LD r4 then ADD r5,r4,r4 -> stall_id=1 for exactly one cycle. Next cycle in EX: forward_XM_A=1, forward_XM_B=1, forward_XM_sel=10, forward_XX_*=0.
- JAL (writes r7, res_src 01) then NOP then ADD using r7 -> forward_XM_A=1, forward_XM_sel=01.
- Load-use condition coincident with flush=1 -> stall_id=0 that cycle; next-cycle forwards all 0; EX is a bubble.
- mem_stall held 3 cycles during forward_XX_A=1 -> outputs held unchanged all 3 cycles, stall_id=1; then resume normally.
- rst asserted during load-use stall -> next edge all outputs 0; with HAZ_PERF_EN, counters read 0. Two load-use events then read perf_stall_cnt=2.
